// File: rtl/sweeper_pkg.sv
// Shared constants for the truth-table sweeper.
//   - StateW and the four state codes (IDLE, SETTLE, SAMPLE, DONE).
//   - Default function-input count and settle length.
// State codes are plain localparams so that older flows can consume them.
package sweeper_pkg;

    localparam int unsigned NInDefault       = 4;
    localparam int unsigned SettleCycDefault = 1;

    localparam int unsigned StateW = 2;
    localparam logic [StateW-1:0] StIdle   = 2'd0;
    localparam logic [StateW-1:0] StSettle = 2'd1;
    localparam logic [StateW-1:0] StSample = 2'd2;
    localparam logic [StateW-1:0] StDone   = 2'd3;

endpackage

// File: rtl/sweep_settle_timer.sv
// Settle-period counter used while the sweeper holds a stimulus value.
//   clk, rst : clock, synchronous active-high reset
//   load     : clear the count (start of a settle period)
//   count    : advance the count; it saturates at the terminal value
//   term     : high during the last settle cycle
module sweep_settle_timer #(
    parameter int unsigned SETTLE_CYC = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic count,
    output logic term
);

    localparam int unsigned CntW = $clog2(SETTLE_CYC + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(SETTLE_CYC - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = '0;
        end else if (count && !term) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign term = (cnt_q == CntLast);

endmodule

// File: rtl/truth_table_sweeper.sv
// Exhaustive stimulus sequencer for a small combinational block: drives every
// input combination, captures the block output into a truth table and,
// optionally, compares the table with an expected one.
//
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   start       begin a sweep (IDLE only); wins over abort in IDLE
//   abort       cancel a sweep in progress
//   expected    expected table, bit i = out for stim value i
//   out_in      output of the block under sweep
//   stim        stimulus (stim[3]=w .. stim[0]=z for four inputs)
//   busy        high while settling/sampling
//   done        one-cycle completion pulse
//   truth_tbl   captured truth table ("table" is a reserved word)
//   pass        captured table equals expected
//   fail_count  number of mismatching entries
//   first_fail  lowest mismatching stim index, 0 if none
//
// Build option: TRUTH_TABLE_SWEEPER_CHECK_EN enables the compare path; when
// undefined, expected is ignored and pass/fail_count/first_fail read 0.
module truth_table_sweeper
    import sweeper_pkg::*;
#(
    parameter int unsigned N_IN       = NInDefault,
    parameter int unsigned SETTLE_CYC = SettleCycDefault
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [2**N_IN-1:0]   expected,
    input  logic                 out_in,
    output logic [N_IN-1:0]      stim,
    output logic                 busy,
    output logic                 done,
    output logic [2**N_IN-1:0]   truth_tbl,
    output logic                 pass,
    output logic [N_IN:0]        fail_count,
    output logic [N_IN-1:0]      first_fail
);

    localparam int unsigned NEnt = 2**N_IN;
    localparam logic [N_IN-1:0] StimLast = '1;

    logic [StateW-1:0] state_q, state_d;
    logic [N_IN-1:0]   stim_q, stim_d;
    logic [NEnt-1:0]   table_q, table_d;
    logic              tmr_load, tmr_count, tmr_term;

    // Qualified events shared with the compare path.
    logic start_en, sample_en, last_en;
    assign start_en  = (state_q == StIdle) && start;
    assign sample_en = (state_q == StSample) && !abort;
    assign last_en   = sample_en && (stim_q == StimLast);

    sweep_settle_timer #(
        .SETTLE_CYC (SETTLE_CYC)
    ) u_settle_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (tmr_load),
        .count (tmr_count),
        .term  (tmr_term)
    );

    always_comb begin
        state_d   = state_q;
        stim_d    = stim_q;
        table_d   = table_q;
        tmr_load  = 1'b0;
        tmr_count = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d  = StSettle;
                    stim_d   = '0;
                    table_d  = '0;
                    tmr_load = 1'b1;
                end
            end
            StSettle: begin
                if (abort) begin
                    state_d = StIdle;
                    stim_d  = '0;
                end else if (tmr_term) begin
                    state_d = StSample;
                end else begin
                    tmr_count = 1'b1;
                end
            end
            StSample: begin
                if (abort) begin
                    state_d = StIdle;
                    stim_d  = '0;
                end else begin
                    table_d[stim_q] = out_in;
                    // Last index is terminal; stim is never allowed to wrap.
                    if (stim_q == StimLast) begin
                        state_d = StDone;
                    end else begin
                        stim_d   = stim_q + N_IN'(1);
                        state_d  = StSettle;
                        tmr_load = 1'b1;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
                stim_d  = '0;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            stim_q  <= '0;
            table_q <= '0;
        end else begin
            state_q <= state_d;
            stim_q  <= stim_d;
            table_q <= table_d;
        end
    end

    assign stim      = stim_q;
    assign busy      = (state_q == StSettle) || (state_q == StSample);
    assign done      = (state_q == StDone);
    assign truth_tbl = table_q;

`ifdef TRUTH_TABLE_SWEEPER_CHECK_EN
    logic [NEnt-1:0] exp_q, exp_d;
    logic            pass_q, pass_d;
    logic [N_IN:0]   fail_cnt_q, fail_cnt_d;
    logic [N_IN-1:0] first_fail_q, first_fail_d;

    always_comb begin
        exp_d        = exp_q;
        pass_d       = pass_q;
        fail_cnt_d   = fail_cnt_q;
        first_fail_d = first_fail_q;
        if (start_en) begin
            exp_d        = expected;
            pass_d       = 1'b0;
            fail_cnt_d   = '0;
            first_fail_d = '0;
        end
        if (sample_en && (out_in != exp_q[stim_q])) begin
            fail_cnt_d = fail_cnt_q + (N_IN+1)'(1);
            if (fail_cnt_q == '0) begin
                first_fail_d = stim_q;
            end
        end
        // Include the final entry's compare so pass is valid while done.
        if (last_en) begin
            pass_d = (fail_cnt_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exp_q        <= '0;
            pass_q       <= 1'b0;
            fail_cnt_q   <= '0;
            first_fail_q <= '0;
        end else begin
            exp_q        <= exp_d;
            pass_q       <= pass_d;
            fail_cnt_q   <= fail_cnt_d;
            first_fail_q <= first_fail_d;
        end
    end

    assign pass       = pass_q;
    assign fail_count = fail_cnt_q;
    assign first_fail = first_fail_q;
`else
    logic unused_check;
    assign unused_check = ^{expected, start_en, last_en};

    assign pass       = 1'b0;
    assign fail_count = '0;
    assign first_fail = '0;
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
module tb_truth_table_sweeper;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] expected = 16'h0;
    logic        out_in;
    logic [3:0]  stim;
    logic        busy, done;
    logic [15:0] truth_tbl;
    logic        pass;
    logic [4:0]  fail_count;
    logic [3:0]  first_fail;

    logic [15:0] func_cur = 16'h0;

    truth_table_sweeper dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .expected   (expected),
        .out_in     (out_in),
        .stim       (stim),
        .busy       (busy),
        .done       (done),
        .truth_tbl  (truth_tbl),
        .pass       (pass),
        .fail_count (fail_count),
        .first_fail (first_fail)
    );

    always #5 clk = ~clk;

    // Function block under sweep: a lookup of the current function.
    assign out_in = func_cur[stim];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passes = 0;

    typedef struct {
        logic [15:0] tbl;
        logic        pass;
        logic [4:0]  fc;
        logic [3:0]  ff;
        int          done_cyc;
    } exp_t;

    exp_t sb[$];
    int   trace[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    endtask

    // Reference: table is the function itself; mismatches are the set bits of f^e.
    function automatic exp_t model(input logic [15:0] f, input logic [15:0] e, input int dc);
        exp_t r;
        logic [15:0] diff;
        r.tbl      = f;
        r.done_cyc = dc;
        diff       = f ^ e;
`ifdef TRUTH_TABLE_SWEEPER_CHECK_EN
        r.fc   = 5'($countones(diff));
        r.pass = (diff == 16'h0);
        r.ff   = 4'd0;
        for (int i = 15; i >= 0; i--) if (diff[i]) r.ff = 4'(i);
`else
        r.fc   = 5'd0;
        r.pass = 1'b0;
        r.ff   = 4'd0;
`endif
        return r;
    endfunction

    // Monitor: trace stimulus while busy, score every done pulse.
    always @(negedge clk) begin
        exp_t e;
        int   bad;
        if (busy) trace.push_back(int'(stim));
        if (done) begin
            chk("done_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("done_cycle", cyc, e.done_cyc);
                chk("table", truth_tbl, e.tbl);
                chk("pass", pass, e.pass);
                chk("fail_count", fail_count, e.fc);
                chk("first_fail", first_fail, e.ff);
                chk("busy_in_done", busy, 1'b0);
                bad = 0;
                if (trace.size() != 32) bad = 100 + trace.size();
                else for (int j = 0; j < 32; j++) if (trace[j] != j / 2) bad++;
                chk("stim_trace", bad, 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_stim"}, stim, 4'd0);
        chk({name, "_busy"}, busy, 1'b0);
        chk({name, "_done"}, done, 1'b0);
        chk({name, "_table"}, truth_tbl, 16'h0);
        chk({name, "_pass"}, pass, 1'b0);
        chk({name, "_fail_count"}, fail_count, 5'd0);
        chk({name, "_first_fail"}, first_fail, 4'd0);
    endtask

    // Issue start; optionally with abort, and optionally re-pulse start mid-sweep.
    task automatic sweep(input logic [15:0] f, input logic [15:0] e,
                         input int restart_at, input bit with_abort);
        bit ok;
        func_cur = f;
        expected = e;
        start    = 1'b1;
        abort    = with_abort;
        trace.delete();
        sb.push_back(model(f, e, cyc + 1 + 32));
        tick();
        start    = 1'b0;
        abort    = 1'b0;
        expected = 16'($urandom);   // must not be re-latched
        chk("busy_after_start", busy, 1'b1);
        if (restart_at > 0) begin
            repeat (restart_at - 1) tick();
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk("done_seen", ok, 1'b1);
        tick();
    endtask

    initial begin
        int seen;
        logic [15:0] f, e;

        // Reset held with start high: nothing may begin.
        rst   = 1'b1;
        start = 1'b1;
        tick();
        tick();
        chk_all_zero("reset");
        rst   = 1'b0;
        start = 1'b0;
        repeat (5) tick();
        chk("idle_after_reset", busy, 1'b0);

        // (w&x)|(y&z)
        sweep(16'hF888, 16'hF888, 0, 1'b0);
        sweep(16'hF888, 16'h0888, 0, 1'b0);
        sweep(16'hF888, 16'hF889, 0, 1'b0);
        // Start re-pulsed at cycle 5 is ignored.
        sweep(16'hF888, 16'hF888, 5, 1'b0);
        // Start and abort together in IDLE: start wins.
        sweep(16'hA5C3, 16'hA5C3, 0, 1'b1);

        // Abort at cycle 10.
        func_cur = 16'hF888;
        expected = 16'hF888;
        start    = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", busy, 1'b0);
        chk("abort_stim", stim, 4'd0);
        seen = 0;
        repeat (40) begin
            if (done) seen++;
            tick();
        end
        chk("abort_no_done", seen, 0);

        // Reset at cycle 15 of a sweep.
        sweep(16'hF888, 16'h0000, 0, 1'b0);   // leaves non-zero results behind
        func_cur = 16'hF888;
        expected = 16'hF888;
        start    = 1'b1;
        tick();
        start = 1'b0;
        repeat (14) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_all_zero("mid_reset");
        repeat (3) tick();
        sweep(16'hF888, 16'hF888, 0, 1'b0);

        // Random functions and expectations.
        repeat (8) begin
            f = 16'($urandom);
            case ($urandom_range(0, 2))
                0:       e = f;
                1:       e = 16'($urandom);
                default: e = f ^ (16'h1 << $urandom_range(0, 15));
            endcase
            sweep(f, e, 0, 1'b0);
        end

        repeat (5) tick();
        chk("scoreboard_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

Sequencer that exhaustively drives a 4-input combinational function block (inputs w, x, y, z; output out) through all 16 input combinations. It samples the block's output for each combination and assembles a 16-bit truth-table vector. It optionally compares that vector against an expected table and reports pass/fail. It sits beside the function block as on-chip self-test control and replaces hand-written exhaustive stimulus.

## Interface
- N_IN, 4: number of function inputs; the table has 2**N_IN entries.
- SETTLE_CYC, 1: cycles (≥1) the stimulus is held before sampling out_in.

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- start  in  1  begin sweep; honoured only in IDLE
- abort  in  1  cancel sweep; honoured in SETTLE/SAMPLE
- expected  in  2**N_IN  expected truth table; bit i = out for stim value i
- out_in  in  1  output of the function block under sweep
- stim  out  N_IN  stimulus; for N_IN=4 stim[3]=w, stim[2]=x, stim[1]=y, stim[0]=z
- busy  out  1  high in SETTLE/SAMPLE
- done  out  1  one-cycle pulse when a sweep completes
- table  out  2**N_IN  captured truth table
- pass  out  1  table==expected; valid while done, held until next start
- fail_count  out  N_IN+1  number of mismatching entries
- first_fail  out  N_IN  lowest mismatching stim index; 0 if none

## Operation
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE, start=1: expected latched, table/fail_count/first_fail/pass cleared, stim←0, settle counter←0, go SETTLE.
- SETTLE: counter increments; after SETTLE_CYC cycles in SETTLE go SAMPLE. stim stable throughout.
- SAMPLE: table[stim]←out_in. On out_in≠latched expected[stim]: fail_count+1; first_fail←stim if this is the first mismatch. If stim==2**N_IN−1 go DONE, else stim+1 and go SETTLE.
- DONE: done=1, pass←(fail_count==0) (registered with the final compare), go IDLE next cycle.
- abort in SETTLE/SAMPLE: go IDLE next edge; no done; table keeps partial contents; stim←0.
- start in any state but IDLE is ignored; start and abort together in IDLE means start.
- stim never wraps mid-sweep; the last index is explicitly terminal.
- rst at any time: state IDLE, stim=0, busy=0, done=0, table=0, pass=0, fail_count=0, first_fail=0.

## Timing
- Per combination: SETTLE_CYC+1 cycles (SETTLE_CYC settle plus 1 sample).
- start sampled at edge k; done high in the cycle following edge k+2**N_IN·(SETTLE_CYC+1). For the defaults that is 32 cycles.
- table, pass, fail_count and first_fail are final when done is high and hold until the next start or rst.
- out_in is sampled at the edge that ends SAMPLE. The function block's combinational delay must fit within SETTLE_CYC cycles.
- busy rises the cycle after start is sampled and falls in DONE.

## Configuration
- TRUTH_TABLE_SWEEPER_CHECK_EN defined: expected latch, compare, pass, fail_count and first_fail are present as described.
- Not defined: compare logic is absent, expected is ignored, and pass/fail_count/first_fail are tied to 0. Sweep timing and table capture are unchanged.

## Structure
- Package sweeper_pkg: state enum (IDLE, SETTLE, SAMPLE, DONE) and its width constant, plus the default N_IN and SETTLE_CYC constants.
- Sub-module sweep_settle_timer: load/count/terminal-flag counter of width clog2(SETTLE_CYC+1), used by SETTLE.

## Test plan
- Reset: assert rst for 2 cycles with start=1 → all outputs 0, state IDLE, no sweep begins until start is seen after rst falls.
- Function (w&x)|(y&z), expected=16'hF888, defaults, 1-cycle start pulse → stim steps 0..15, each value held 2 cycles; done 32 cycles after start; table=16'hF888, pass=1, fail_count=0, first_fail=0.
- Same function, expected=16'h0888 → table=16'hF888, pass=0, fail_count=4, first_fail=12.
- Same function, expected=16'hF889 → fail_count=1, first_fail=0, pass=0.
- start pulsed again at cycle 5 of a sweep → ignored, done still at cycle 32. Separately, abort at cycle 10 → busy=0 next cycle, no done pulse, stim=0.
- rst asserted at cycle 15 of a sweep → next cycle all outputs 0. A fresh start after that completes normally with table=16'hF888.
